dual_dmem_responder: RTL and testbench



---
 rtl/dual_dmem_responder.sv | 140 ++++++++++++++
 tb/tb_dual_dmem_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dual_dmem_responder.sv
// Shared data memory for the dual-core build: two combinational read ports,
// one array write per cycle, with an in-order posted write buffer that absorbs collisions.
module dual_dmem_responder #(
  parameter int ADDR_W   = 7,
  parameter int WB_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [31:0]                   c0_addr_i,
  input  logic [31:0]                   c0_wdata_i,
  input  logic                          c0_memread_i,
  input  logic                          c0_memwrite_i,
  output logic [31:0]                   c0_rdata_o,
  input  logic [31:0]                   c1_addr_i,
  input  logic [31:0]                   c1_wdata_i,
  input  logic                          c1_memread_i,
  input  logic                          c1_memwrite_i,
  output logic [31:0]                   c1_rdata_o,
  output logic [$clog2(WB_DEPTH):0]     wbuf_count_o,
  output logic                          wbuf_full_o,
  output logic [1:0]                    drop_o,
  output logic                          overflow_o
);

  localparam int PTR_W  = $clog2(WB_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int FREE_W = CNT_W + 1;
  localparam int WORDS  = 1 << ADDR_W;

  logic [31:0]       r_mem     [WORDS];
  logic [ADDR_W-1:0] r_bufIdx  [WB_DEPTH];
  logic [31:0]       r_bufData [WB_DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;

  logic [ADDR_W-1:0] w_idx0;
  logic [ADDR_W-1:0] w_idx1;
  logic [31:0]       w_rd0;
  logic [31:0]       w_rd1;
  logic [PTR_W-1:0]  w_slot;
  logic [PTR_W-1:0]  w_slot1;
  logic              w_drain;
  logic              w_want0;
  logic              w_want1;
  logic              w_grant0;
  logic              w_grant1;
  logic [FREE_W-1:0] w_free;
  logic [FREE_W-1:0] w_need1;
  logic [1:0]        w_drop;
  logic              w_memWe;
  logic [ADDR_W-1:0] w_memIdx;
  logic [31:0]       w_memData;
  logic              w_unused;

  assign w_idx0 = c0_addr_i[ADDR_W+1:2];
  assign w_idx1 = c1_addr_i[ADDR_W+1:2];
  assign w_unused = ^{c0_addr_i[31:ADDR_W+2], c0_addr_i[1:0],
                      c1_addr_i[31:ADDR_W+2], c1_addr_i[1:0]};

  // Walk valid entries oldest to youngest so the youngest matching store wins.
  always_comb begin
    w_rd0  = r_mem[w_idx0];
    w_rd1  = r_mem[w_idx1];
    w_slot = r_head;
    for (int k = 0; k < WB_DEPTH; k++) begin
      w_slot = r_head + PTR_W'(k);
      if (CNT_W'(k) < r_count) begin
        if (r_bufIdx[w_slot] == w_idx0) w_rd0 = r_bufData[w_slot];
        if (r_bufIdx[w_slot] == w_idx1) w_rd1 = r_bufData[w_slot];
      end
    end
    if (rst_i || !c0_memread_i) w_rd0 = '0;
    if (rst_i || !c1_memread_i) w_rd1 = '0;
  end

  assign c0_rdata_o = w_rd0;
  assign c1_rdata_o = w_rd1;

  assign w_drain  = (r_count != '0);
  assign w_want0  = c0_memwrite_i && w_drain;
  assign w_want1  = c1_memwrite_i && (w_drain || c0_memwrite_i);
  assign w_free   = FREE_W'(WB_DEPTH) - {1'b0, r_count} + FREE_W'(w_drain);
  assign w_grant0 = w_want0 && (w_free >= FREE_W'(1));
  assign w_need1  = w_grant0 ? FREE_W'(2) : FREE_W'(1);
  assign w_grant1 = w_want1 && (w_free >= w_need1);
  assign w_slot1  = r_tail + PTR_W'(w_grant0);
  assign w_drop   = rst_i ? 2'b00 : {w_want1 && !w_grant1, w_want0 && !w_grant0};

  // The drain always owns the single array write; otherwise a direct store takes it.
  always_comb begin
    w_memWe   = 1'b0;
    w_memIdx  = '0;
    w_memData = '0;
    if (w_drain) begin
      w_memWe   = 1'b1;
      w_memIdx  = r_bufIdx[r_head];
      w_memData = r_bufData[r_head];
    end else if (c0_memwrite_i) begin
      w_memWe   = 1'b1;
      w_memIdx  = w_idx0;
      w_memData = c0_wdata_i;
    end else if (c1_memwrite_i) begin
      w_memWe   = 1'b1;
      w_memIdx  = w_idx1;
      w_memData = c1_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < WORDS; i++) r_mem[i] <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_memWe) r_mem[w_memIdx] <= w_memData;
      if (w_grant0) begin
        r_bufIdx[r_tail]  <= w_idx0;
        r_bufData[r_tail] <= c0_wdata_i;
      end
      if (w_grant1) begin
        r_bufIdx[w_slot1]  <= w_idx1;
        r_bufData[w_slot1] <= c1_wdata_i;
      end
      r_head  <= r_head + PTR_W'(w_drain);
      r_tail  <= r_tail + PTR_W'(w_grant0) + PTR_W'(w_grant1);
      r_count <= r_count - CNT_W'(w_drain) + CNT_W'(w_grant0) + CNT_W'(w_grant1);
      if (|w_drop) r_overflow <= 1'b1;
    end
  end

  assign wbuf_count_o = r_count;
  assign wbuf_full_o  = (r_count == CNT_W'(WB_DEPTH));
  assign drop_o       = w_drop;
  assign overflow_o   = r_overflow;

endmodule

// File: tb/tb_dual_dmem_responder.sv
// Scoreboard bench for dual_dmem_responder: stimulus queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_dual_dmem_responder;

  localparam int ADDR_W   = 7;
  localparam int WB_DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] c0_addr_i, c0_wdata_i, c1_addr_i, c1_wdata_i;
  logic        c0_memread_i, c0_memwrite_i, c1_memread_i, c1_memwrite_i;
  logic [31:0] c0_rdata_o, c1_rdata_o;
  logic [2:0]  wbuf_count_o;
  logic        wbuf_full_o;
  logic [1:0]  drop_o;
  logic        overflow_o;

  dual_dmem_responder #(.ADDR_W(ADDR_W), .WB_DEPTH(WB_DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .c0_addr_i(c0_addr_i), .c0_wdata_i(c0_wdata_i),
    .c0_memread_i(c0_memread_i), .c0_memwrite_i(c0_memwrite_i), .c0_rdata_o(c0_rdata_o),
    .c1_addr_i(c1_addr_i), .c1_wdata_i(c1_wdata_i),
    .c1_memread_i(c1_memread_i), .c1_memwrite_i(c1_memwrite_i), .c1_rdata_o(c1_rdata_o),
    .wbuf_count_o(wbuf_count_o), .wbuf_full_o(wbuf_full_o),
    .drop_o(drop_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef enum int {SEL_RD0, SEL_RD1, SEL_COUNT, SEL_FULL, SEL_DROP, SEL_OVF} sel_t;
  typedef struct {
    int          cycle;
    sel_t        sel;
    logic [31:0] value;
    string       name;
  } sbEntry_t;

  sbEntry_t sbQueue[$];
  int cycleCount  = 0;
  int testsRun    = 0;
  int testsFailed = 0;

  always @(posedge clk_i) cycleCount <= cycleCount + 1;

  function automatic logic [31:0] sampleOutput(input sel_t sel);
    case (sel)
      SEL_RD0:   return c0_rdata_o;
      SEL_RD1:   return c1_rdata_o;
      SEL_COUNT: return {29'd0, wbuf_count_o};
      SEL_FULL:  return {31'd0, wbuf_full_o};
      SEL_DROP:  return {30'd0, drop_o};
      default:   return {31'd0, overflow_o};
    endcase
  endfunction

  task automatic pushExpect(input sel_t sel, input logic [31:0] value, input string name);
    sbEntry_t e;
    e.cycle = cycleCount;
    e.sel   = sel;
    e.value = value;
    e.name  = name;
    sbQueue.push_back(e);
  endtask

  task automatic checkOutput(input sbEntry_t e);
    logic [31:0] act;
    act = sampleOutput(e.sel);
    testsRun++;
    if (e.cycle != cycleCount) begin
      testsFailed++;
      $display("[TB] FAIL %s: stale entry from cycle %0d seen at cycle %0d", e.name, e.cycle, cycleCount);
    end else if (act !== e.value) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.value);
    end
  endtask

  // Monitor: at mid-cycle, compare every expectation queued for this cycle.
  always @(negedge clk_i) begin
    while (sbQueue.size() > 0 && sbQueue[0].cycle <= cycleCount)
      checkOutput(sbQueue.pop_front());
  end

  task automatic applyStimulus(input logic rst,
                               input logic [31:0] a0, input logic [31:0] d0,
                               input logic r0, input logic w0,
                               input logic [31:0] a1, input logic [31:0] d1,
                               input logic r1, input logic w1);
    @(posedge clk_i);
    #1;
    rst_i = rst;
    c0_addr_i = a0; c0_wdata_i = d0; c0_memread_i = r0; c0_memwrite_i = w0;
    c1_addr_i = a1; c1_wdata_i = d1; c1_memread_i = r1; c1_memwrite_i = w1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  int burstCount [8] = '{0, 1, 2, 3, 4, 4, 4, 4};
  int burstDrop  [8] = '{0, 0, 0, 0, 2, 2, 2, 2};
  int burstFull  [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
  int burstOvf   [8] = '{0, 0, 0, 0, 0, 1, 1, 1};

  initial begin
    rst_i = 1'b1;
    c0_addr_i = '0; c0_wdata_i = '0; c0_memread_i = 1'b0; c0_memwrite_i = 1'b0;
    c1_addr_i = '0; c1_wdata_i = '0; c1_memread_i = 1'b0; c1_memwrite_i = 1'b0;

    applyStimulus(1'b1, 32'h0, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    pushExpect(SEL_RD0, 32'h0, "rst_rdata_forced0");
    applyStimulus(1'b1, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    pushExpect(SEL_COUNT, 32'd0, "rst_count");
    pushExpect(SEL_FULL,  32'd0, "rst_full");
    pushExpect(SEL_OVF,   32'd0, "rst_overflow");
    pushExpect(SEL_DROP,  32'd0, "rst_drop");

    applyStimulus(1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    pushExpect(SEL_COUNT, 32'd0, "single_store_count");
    applyStimulus(1'b0, 32'h10, 0, 1'b1, 1'b0, 32'h10, 0, 1'b1, 1'b0);
    pushExpect(SEL_RD0, 32'hDEADBEEF, "single_store_rd0");
    pushExpect(SEL_RD1, 32'hDEADBEEF, "single_store_rd1");
    pushExpect(SEL_COUNT, 32'd0, "single_store_count_after");

    applyStimulus(1'b0, 32'h20, 32'h11111111, 1'b0, 1'b1, 32'h24, 32'h22222222, 1'b0, 1'b1);
    pushExpect(SEL_COUNT, 32'd0, "dual_store_count_pre");
    applyStimulus(1'b0, 32'h20, 0, 1'b1, 1'b0, 32'h24, 0, 1'b1, 1'b0);
    pushExpect(SEL_RD0, 32'h11111111, "dual_store_direct");
    pushExpect(SEL_RD1, 32'h22222222, "dual_store_forward");
    pushExpect(SEL_COUNT, 32'd1, "dual_store_count1");
    applyStimulus(1'b0, 32'h24, 0, 1'b1, 1'b0, 32'h20, 0, 1'b1, 1'b0);
    pushExpect(SEL_RD0, 32'h22222222, "dual_store_drained_24");
    pushExpect(SEL_RD1, 32'h11111111, "dual_store_drained_20");
    pushExpect(SEL_COUNT, 32'd0, "dual_store_count0");

    applyStimulus(1'b0, 32'h40, 32'hA, 1'b1, 1'b1, 32'h40, 32'hB, 1'b0, 1'b1);
    pushExpect(SEL_RD0, 32'h0, "same_addr_old_value");
    applyStimulus(1'b0, 32'h40, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    pushExpect(SEL_RD0, 32'hB, "same_addr_forward_c1");
    pushExpect(SEL_COUNT, 32'd1, "same_addr_count1");
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 32'h40, 0, 1'b1, 1'b0);
    pushExpect(SEL_RD1, 32'hB, "same_addr_final_c1");
    pushExpect(SEL_COUNT, 32'd0, "same_addr_count0");

    applyStimulus(1'b0, 32'h0, 32'h12345678, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h203, 0, 1'b1, 1'b0, 32'h200, 0, 1'b1, 1'b0);
    pushExpect(SEL_RD0, 32'h12345678, "alias_203");
    pushExpect(SEL_RD1, 32'h12345678, "alias_200");
    applyStimulus(1'b0, 32'h200, 0, 1'b0, 1'b0, 32'h200, 0, 1'b0, 1'b0);
    pushExpect(SEL_RD0, 32'h0, "noread_rd0_zero");
    pushExpect(SEL_RD1, 32'h0, "noread_rd1_zero");

    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 32'h100 + 32'(8 * k), 32'hC0000000 + 32'(k), 1'b0, 1'b1,
                    32'h104 + 32'(8 * k), 32'hC1000000 + 32'(k), 1'b0, 1'b1);
      pushExpect(SEL_COUNT, 32'(burstCount[k]), $sformatf("burst%0d_count", k));
      pushExpect(SEL_DROP,  32'(burstDrop[k]),  $sformatf("burst%0d_drop", k));
      pushExpect(SEL_FULL,  32'(burstFull[k]),  $sformatf("burst%0d_full", k));
      pushExpect(SEL_OVF,   32'(burstOvf[k]),   $sformatf("burst%0d_overflow", k));
    end
    applyStimulus(1'b0, 32'h138, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    pushExpect(SEL_RD0, 32'hC0000007, "full_forward_youngest");
    pushExpect(SEL_COUNT, 32'd4, "full_idle_count");
    pushExpect(SEL_DROP, 32'd0, "full_idle_drop");
    pushExpect(SEL_OVF, 32'd1, "full_idle_overflow");
    idle();
    idle();
    idle();
    applyStimulus(1'b0, 32'h120, 0, 1'b1, 1'b0, 32'h124, 0, 1'b1, 1'b0);
    pushExpect(SEL_RD0, 32'hC0000004, "burst_granted_c0");
    pushExpect(SEL_RD1, 32'h0, "burst_dropped_c1");
    pushExpect(SEL_COUNT, 32'd0, "burst_drained_count");
    pushExpect(SEL_OVF, 32'd1, "overflow_sticky");
    applyStimulus(1'b0, 32'h11C, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    pushExpect(SEL_RD0, 32'hC1000003, "burst_c1_k3");

    applyStimulus(1'b0, 32'h60, 32'h60606060, 1'b0, 1'b1, 32'h64, 32'h64646464, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h68, 32'h68686868, 1'b0, 1'b1, 32'h6C, 32'h6C6C6C6C, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h70, 32'h70707070, 1'b0, 1'b1, 32'h74, 32'h74747474, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h64, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    pushExpect(SEL_COUNT, 32'd3, "pre_reset_count3");
    pushExpect(SEL_OVF, 32'd1, "pre_reset_overflow");
    pushExpect(SEL_RD0, 32'h0, "in_reset_rdata");
    applyStimulus(1'b0, 32'h64, 0, 1'b1, 1'b0, 32'h74, 0, 1'b1, 1'b0);
    pushExpect(SEL_RD0, 32'h0, "post_reset_64");
    pushExpect(SEL_RD1, 32'h0, "post_reset_74");
    pushExpect(SEL_COUNT, 32'd0, "post_reset_count");
    pushExpect(SEL_OVF, 32'd0, "post_reset_overflow");
    applyStimulus(1'b0, 32'h60, 0, 1'b1, 1'b0, 32'h70, 0, 1'b1, 1'b0);
    pushExpect(SEL_RD0, 32'h0, "post_reset_60");
    pushExpect(SEL_RD1, 32'h0, "post_reset_70");

    idle();
    @(negedge clk_i);
    #1;
    if (sbQueue.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sbQueue.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
